mac_tile_dbuf: RTL and testbench

- Next-generation systolic-array processing element.
- Supports two runtime-selectable dataflows:
  - weight-stationary (WS), with a double-buffered weight so the next kernel preloads while the current one executes;
  - output-stationary (OS), with an internal accumulator and a shift-south drain chain.
- Instantiated in a ROWS x COLS grid: activations/instructions flow west->east, partial sums (WS) or weights/drain data (OS) flow north->south.

---
 rtl/mac_tile_dbuf_if.sv | 26 ++
 rtl/mac_tile_dbuf.sv | 170 +++++++++++++++++
 tb/tb_mac_tile_dbuf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mac_tile_dbuf_if.sv
// Tile-boundary bundle for mac_tile_dbuf: west/north inputs, east/south
// outputs and the debug weight tap. The driver side (array edge or testbench)
// uses the master modport; the tile itself uses the slave modport.
interface mac_tile_dbuf_if #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16
);
  logic               mode;
  logic [BW-1:0]      in_w;
  logic [2:0]         inst_w;
  logic [PSUM_BW-1:0] in_n;
  logic [BW-1:0]      out_e;
  logic [2:0]         inst_e;
  logic [PSUM_BW-1:0] out_s;
  logic [BW-1:0]      debug_tile_weight;

  modport master (
    output mode, in_w, inst_w, in_n,
    input  out_e, inst_e, out_s, debug_tile_weight
  );

  modport slave (
    input  mode, in_w, inst_w, in_n,
    output out_e, inst_e, out_s, debug_tile_weight
  );
endinterface

// File: rtl/mac_tile_dbuf.sv
// Systolic-array processing element with two runtime dataflows.
//   WS (mode=0): a double-buffered weight; the shadow slot preloads the next
//     kernel while the active slot feeds the MAC. Partial sums flow south.
//   OS (mode=1): a local accumulator; weights enter from the north and are
//     forwarded south, and the drain chain shifts accumulators south.
// Instruction bits: [0] load, [1] execute, [2] swap (WS) / drain (OS).
// Activations and instructions pass west->east with one cycle of latency.
module mac_tile_dbuf #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  mac_tile_dbuf_if.slave   bus
);

  localparam int PW = PSUM_BW;
  localparam int MW = 2 * BW + 1;

  localparam logic signed [PW-1:0] PSUM_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] PSUM_MIN = {1'b1, {(PW-1){1'b0}}};

  // Signed add with one guard bit; clamps when SAT is set, else wraps.
  function automatic logic signed [PW-1:0] add_psum(
    input logic signed [PW-1:0] a,
    input logic signed [PW-1:0] b
  );
    logic signed [PW:0] sum_ext;
    sum_ext = (PW+1)'(a) + (PW+1)'(b);
    if ((SAT != 0) && (sum_ext[PW] != sum_ext[PW-1])) begin
      add_psum = sum_ext[PW] ? PSUM_MIN : PSUM_MAX;
    end else begin
      add_psum = sum_ext[PW-1:0];
    end
  endfunction

  // Architectural state.
  logic [BW-1:0]          r_out_e;
  logic [2:0]             r_inst_e;
  logic [PW-1:0]          r_out_s;
  logic signed [PW-1:0]   r_acc;
  logic signed [BW-1:0]   r_w_act;
  logic signed [BW-1:0]   r_w_sh;
  logic                   r_shadow_full;

  // Instruction decode.
  logic w_load;
  logic w_exec;
  logic w_swap;
  logic w_swap_take;
  logic w_capture;
  logic w_ws_exec;
  logic w_os_exec;
  logic w_os_drain;

  assign w_load = bus.inst_w[0];
  assign w_exec = bus.inst_w[1];
  assign w_swap = bus.inst_w[2];

  // A swap only moves weights when the shadow slot holds one. A load lands in
  // the shadow slot if it is empty, or if this same cycle's swap empties it.
  assign w_swap_take = ~bus.mode & w_swap & r_shadow_full;
  assign w_capture   = ~bus.mode & w_load & (~r_shadow_full | w_swap_take);

  // Swap outranks load outranks execute in WS; in OS drain outranks execute
  // and the load bit has no effect on the datapath.
  assign w_ws_exec  = ~bus.mode & w_exec & ~w_load & ~w_swap;
  assign w_os_exec  =  bus.mode & w_exec & ~w_swap;
  assign w_os_drain =  bus.mode & w_swap;

  // Multiplier operands: activation is unsigned, so it gets a zero MSB to act
  // as a non-negative signed value; weights are already two's complement.
  logic signed [BW:0]    w_act_u;
  logic signed [BW-1:0]  w_os_wt;
  logic signed [MW-1:0]  w_ws_prod_raw;
  logic signed [MW-1:0]  w_os_prod_raw;
  logic signed [PW-1:0]  w_ws_prod;
  logic signed [PW-1:0]  w_os_prod;
  logic signed [PW-1:0]  w_os_wt_ext;
  logic signed [PW-1:0]  w_ws_sum;
  logic signed [PW-1:0]  w_os_sum;

  assign w_act_u       = {1'b0, bus.in_w};
  assign w_os_wt       = bus.in_n[BW-1:0];
  assign w_ws_prod_raw = MW'(w_act_u) * MW'(r_w_act);
  assign w_os_prod_raw = MW'(w_act_u) * MW'(w_os_wt);
  assign w_ws_prod     = PW'(w_ws_prod_raw);
  assign w_os_prod     = PW'(w_os_prod_raw);
  assign w_os_wt_ext   = PW'(w_os_wt);
  assign w_ws_sum      = add_psum(w_ws_prod, $signed(bus.in_n));
  assign w_os_sum      = add_psum(r_acc, w_os_prod);

  // Next south output and accumulator value for the current mode/instruction.
  logic [PW-1:0]         w_out_s_nxt;
  logic signed [PW-1:0]  w_acc_nxt;

  // Select south output and accumulator update.
  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    w_out_s_nxt = bus.in_n;
    w_acc_nxt   = r_acc;
    if (bus.mode) begin
      w_out_s_nxt = '0;
      if (w_os_drain) begin
        w_out_s_nxt = r_acc;
        w_acc_nxt   = $signed(bus.in_n);
      end else if (w_os_exec) begin
        w_out_s_nxt = w_os_wt_ext;
        w_acc_nxt   = w_os_sum;
      end
    end else if (w_ws_exec) begin
      w_out_s_nxt = w_ws_sum;
    end
  end

  // West-to-east pipeline: activation (held between uses) and instruction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      r_out_e  <= '0;
      r_inst_e <= '0;
    end else begin
      if (w_load || w_exec) begin
        r_out_e <= bus.in_w;
      end
      // The first load after the shadow empties stops here; later ones travel
      // on to fill tiles further east.
      r_inst_e <= {w_swap, w_exec, w_load & r_shadow_full};
    end
  end

  // Double-buffered WS weight: shadow capture and shadow-to-active swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_act       <= '0;
      r_w_sh        <= '0;
      r_shadow_full <= 1'b0;
    end else begin
      if (w_swap_take) begin
        r_w_act <= r_w_sh;
      end
      if (w_capture) begin
        r_w_sh        <= bus.in_w;
        r_shadow_full <= 1'b1;
      end else if (w_swap_take) begin
        r_shadow_full <= 1'b0;
      end
    end
  end

  // South output register and OS accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_s <= '0;
      r_acc   <= '0;
    end else begin
      r_out_s <= w_out_s_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  assign bus.out_e             = r_out_e;
  assign bus.inst_e            = r_inst_e;
  assign bus.out_s             = r_out_s;
  assign bus.debug_tile_weight = r_w_act;

endmodule

// File: tb/tb_mac_tile_dbuf.sv
// Directed bench for mac_tile_dbuf. Two tiles (wrapping and saturating) see
// identical stimulus; expected outputs are queued as each step is driven and
// compared one cycle later.
module tb_mac_tile_dbuf;

  localparam int BW = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_tile_dbuf_if #(.BW(BW), .PSUM_BW(PW)) bus0 ();
  mac_tile_dbuf_if #(.BW(BW), .PSUM_BW(PW)) bus1 ();

  mac_tile_dbuf #(.BW(BW), .PSUM_BW(PW), .SAT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mac_tile_dbuf #(.BW(BW), .PSUM_BW(PW), .SAT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct {
    string         tag;
    logic [PW-1:0] s0;
    logic [PW-1:0] s1;
    logic [BW-1:0] e;
    logic [2:0]    i;
    logic [BW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input string field,
                     input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic m, input logic [2:0] inst,
                       input logic [BW-1:0] iw, input logic [PW-1:0] inn);
    reset       = r;
    bus0.mode   = m;
    bus0.inst_w = inst;
    bus0.in_w   = iw;
    bus0.in_n   = inn;
    bus1.mode   = m;
    bus1.inst_w = inst;
    bus1.in_w   = iw;
    bus1.in_n   = inn;
  endtask

  task automatic compare_one();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard observed=empty expected=entry");
    end else begin
      x = sb.pop_front();
      chk(x.tag, "sat0.out_s",  bus0.out_s, x.s0);
      chk(x.tag, "sat0.out_e",  PW'(bus0.out_e), PW'(x.e));
      chk(x.tag, "sat0.inst_e", PW'(bus0.inst_e), PW'(x.i));
      chk(x.tag, "sat0.dbg_w",  PW'(bus0.debug_tile_weight), PW'(x.d));
      chk(x.tag, "sat1.out_s",  bus1.out_s, x.s1);
      chk(x.tag, "sat1.out_e",  PW'(bus1.out_e), PW'(x.e));
      chk(x.tag, "sat1.inst_e", PW'(bus1.inst_e), PW'(x.i));
      chk(x.tag, "sat1.dbg_w",  PW'(bus1.debug_tile_weight), PW'(x.d));
    end
  endtask

  // One clock: drive on the falling edge, queue the expectation, sample 1ns
  // after the rising edge.
  task automatic step(input string tag, input logic r, input logic m,
                      input logic [2:0] inst, input logic [BW-1:0] iw,
                      input logic [PW-1:0] inn,
                      input logic [PW-1:0] s0, input logic [PW-1:0] s1,
                      input logic [BW-1:0] e, input logic [2:0] i,
                      input logic [BW-1:0] d);
    exp_t x;
    @(negedge clk);
    drive(r, m, inst, iw, inn);
    x.tag = tag;
    x.s0  = s0;
    x.s1  = s1;
    x.e   = e;
    x.i   = i;
    x.d   = d;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_one();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    drive(1'b1, 1'b0, 3'b000, 4'h0, 16'h0000);

    // Reset with random inputs clears every visible register.
    step("rst0", 1'b1, 1'($urandom), 3'($urandom), 4'($urandom), 16'($urandom),
         16'h0000, 16'h0000, 4'h0, 3'b000, 4'h0);
    step("rst1", 1'b1, 1'($urandom), 3'($urandom), 4'($urandom), 16'($urandom),
         16'h0000, 16'h0000, 4'h0, 3'b000, 4'h0);

    // WS idle: psum passes through, activation holds.
    step("idle1", 0, 0, 3'b000, 4'h0, 16'h1234, 16'h1234, 16'h1234, 4'h0, 3'b000, 4'h0);
    step("idle2", 0, 0, 3'b000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 3'b000, 4'h0);

    // Load gating: first load absorbed, second forwarded east and ignored here.
    step("ld1",   0, 0, 3'b001, 4'hD, 16'h0011, 16'h0011, 16'h0011, 4'hD, 3'b000, 4'h0);
    step("ld2",   0, 0, 3'b001, 4'h5, 16'h0022, 16'h0022, 16'h0022, 4'h5, 3'b001, 4'h0);
    step("swap",  0, 0, 3'b100, 4'h9, 16'h0033, 16'h0033, 16'h0033, 4'h5, 3'b100, 4'hD);

    // WS MAC with weight -3: 7*-3+10 = -11, 15*-3+256 = 211.
    step("mac",   0, 0, 3'b010, 4'h7, 16'h000A, 16'hFFF5, 16'hFFF5, 4'h7, 3'b010, 4'hD);
    step("mac2",  0, 0, 3'b010, 4'hF, 16'h0100, 16'h00D3, 16'h00D3, 4'hF, 3'b010, 4'hD);

    // Swap with an empty shadow changes nothing.
    step("swp_e", 0, 0, 3'b100, 4'h3, 16'h0000, 16'h0000, 16'h0000, 4'hF, 3'b100, 4'hD);

    // Fill shadow with 6, then swap+load: active=6, shadow=2 and still full.
    step("ld3",   0, 0, 3'b001, 4'h6, 16'h0001, 16'h0001, 16'h0001, 4'h6, 3'b000, 4'hD);
    step("swp_ld",0, 0, 3'b101, 4'h2, 16'h0002, 16'h0002, 16'h0002, 4'h2, 3'b101, 4'h6);

    // Load+execute is a load only (and shadow full, so no capture); psum passes.
    step("ld_ex", 0, 0, 3'b011, 4'h4, 16'h0050, 16'h0050, 16'h0050, 4'h4, 3'b011, 4'h6);
    step("swap2", 0, 0, 3'b100, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h4, 3'b100, 4'h2);

    // Weight 2: 3*2-1 = 5; 15*2+0x7FF0 overflows (wrap vs clamp).
    step("mac3",  0, 0, 3'b010, 4'h3, 16'hFFFF, 16'h0005, 16'h0005, 4'h3, 3'b010, 4'h2);
    step("ws_sat",0, 0, 3'b010, 4'hF, 16'h7FF0, 16'h800E, 16'h7FFF, 4'hF, 3'b010, 4'h2);

    // Two idle cycles before switching to OS.
    step("idle3", 0, 0, 3'b000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'hF, 3'b000, 4'h2);
    step("idle4", 0, 0, 3'b000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'hF, 3'b000, 4'h2);

    // OS: three 2*3 accumulations, weight forwarded south each cycle.
    step("os_ex1",0, 1, 3'b010, 4'h2, 16'h0003, 16'h0003, 16'h0003, 4'h2, 3'b010, 4'h2);
    step("os_ex2",0, 1, 3'b010, 4'h2, 16'h0003, 16'h0003, 16'h0003, 4'h2, 3'b010, 4'h2);
    step("os_ex3",0, 1, 3'b010, 4'h2, 16'h0003, 16'h0003, 16'h0003, 4'h2, 3'b010, 4'h2);

    // Drain chain: 18 leaves, 0x42 shifts in, then leaves.
    step("os_dr1",0, 1, 3'b100, 4'h0, 16'h0042, 16'h0012, 16'h0012, 4'h2, 3'b100, 4'h2);
    step("os_dr2",0, 1, 3'b100, 4'h0, 16'h0000, 16'h0042, 16'h0042, 4'h2, 3'b100, 4'h2);

    // OS idle drives zero; a load bit does not touch weights and is absorbed.
    step("os_idl",0, 1, 3'b000, 4'h0, 16'h5555, 16'h0000, 16'h0000, 4'h2, 3'b000, 4'h2);
    step("os_ld", 0, 1, 3'b001, 4'h9, 16'h0007, 16'h0000, 16'h0000, 4'h9, 3'b000, 4'h2);

    // Drain beats execute; preload acc = 0x7FF0.
    step("os_exd",0, 1, 3'b110, 4'h5, 16'h7FF0, 16'h0000, 16'h0000, 4'h5, 3'b110, 4'h2);

    // 0x7FF0 + 15*7: wraps to 0x8059 or clamps to 0x7FFF. Upper in_n bits ignored.
    step("os_sat",0, 1, 3'b010, 4'hF, 16'hABC7, 16'h0007, 16'h0007, 4'hF, 3'b010, 4'h2);
    step("os_dr3",0, 1, 3'b100, 4'h0, 16'h8005, 16'h8059, 16'h7FFF, 4'hF, 3'b100, 4'h2);

    // 0x8005 + 15*-8: wraps to 0x7F8D or clamps to 0x8000.
    step("os_neg",0, 1, 3'b010, 4'hF, 16'h0008, 16'hFFF8, 16'hFFF8, 4'hF, 3'b010, 4'h2);
    step("os_dr4",0, 1, 3'b100, 4'h0, 16'h0000, 16'h7F8D, 16'h8000, 4'hF, 3'b100, 4'h2);

    // Reset mid-operation discards the accumulator and the weights.
    step("pre_rst",0,1, 3'b010, 4'h1, 16'h0001, 16'h0001, 16'h0001, 4'h1, 3'b010, 4'h2);
    step("rst_mid",1,1, 3'b010, 4'h3, 16'h0003, 16'h0000, 16'h0000, 4'h0, 3'b000, 4'h0);
    step("post_rst",0,1,3'b100, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 3'b100, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
